// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter and the requesters that sit in front of it.
// A request payload is carried at the widest supported address width and trimmed at the memory port.
package dmem_arbiter_pkg;

  localparam int unsigned MEM_ADDR_W_MAX = 32;

  // The state encoding is one-hot on the grant states, so the grant vector is read straight off the state.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT0 = 2'b01,
    ARB_GNT1 = 2'b10
  } arb_state_e;

  typedef struct packed {
    logic [MEM_ADDR_W_MAX-1:0] addr;
    logic [31:0]               wdata;
    logic [3:0]                bmask;
    logic                      wren;
  } mem_req_t;

  function automatic mem_req_t make_req(
    input logic [MEM_ADDR_W_MAX-1:0] addr,
    input logic [31:0]               wdata,
    input logic [3:0]                bmask,
    input logic                      wren
  );
    mem_req_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.bmask = bmask;
    r.wren  = wren;
    return r;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory's valid/ready port between the LSU (P0) and a
// secondary master (P1), with an optional bounded lock for short atomic sequences.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = 4,
  parameter int ADDR_W   = 18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,

  input  logic              i_P0_VALID,
  output logic              o_P0_READY,
  input  logic [ADDR_W-1:0] i_P0_ADDR,
  input  logic [31:0]       i_P0_WDATA,
  input  logic [3:0]        i_P0_BMASK,
  input  logic              i_P0_WREN,
  input  logic              i_P0_LOCK,
  output logic [31:0]       o_P0_RDATA,

  input  logic              i_P1_VALID,
  output logic              o_P1_READY,
  input  logic [ADDR_W-1:0] i_P1_ADDR,
  input  logic [31:0]       i_P1_WDATA,
  input  logic [3:0]        i_P1_BMASK,
  input  logic              i_P1_WREN,
  input  logic              i_P1_LOCK,
  output logic [31:0]       o_P1_RDATA,

  output logic              o_VALID,
  input  logic              i_READY,
  output logic [ADDR_W-1:0] o_ADDR,
  output logic [31:0]       o_WDATA,
  output logic [3:0]        o_BMASK,
  output logic              o_WREN,
  input  logic [31:0]       i_RDATA,

  output logic [1:0]        o_GNT,
  output logic              o_BUSY
);

  localparam int LCW = $clog2(LOCK_MAX + 1);

  arb_state_e     state_q, state_d;
  logic           last_gnt_q, last_gnt_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

  mem_req_t p0_req, p1_req, sel_req;
  logic     gnt_valid, gnt_lock, handshake, budget_left;

  assign p0_req = make_req(MEM_ADDR_W_MAX'(i_P0_ADDR), i_P0_WDATA, i_P0_BMASK, i_P0_WREN);
  assign p1_req = make_req(MEM_ADDR_W_MAX'(i_P1_ADDR), i_P1_WDATA, i_P1_BMASK, i_P1_WREN);

  // View of the currently granted port's valid and lock request.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_lock  = 1'b0;
    unique case (state_q)
      ARB_GNT0: begin
        gnt_valid = i_P0_VALID;
        gnt_lock  = i_P0_LOCK;
      end
      ARB_GNT1: begin
        gnt_valid = i_P1_VALID;
        gnt_lock  = i_P1_LOCK;
      end
      default: ;
    endcase
  end

  assign handshake   = gnt_valid & i_READY;
  assign budget_left = (lock_cnt_q + LCW'(1)) < LCW'(LOCK_MAX);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // last_gnt_q names the port granted most recently; on a tie the other one wins.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_P0_VALID && (!i_P1_VALID || last_gnt_q)) begin
          state_d    = ARB_GNT0;
          last_gnt_d = 1'b0;
          lock_cnt_d = '0;
        end else if (i_P1_VALID) begin
          state_d    = ARB_GNT1;
          last_gnt_d = 1'b1;
          lock_cnt_d = '0;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        if (handshake) begin
          if (gnt_lock && budget_left) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (!gnt_valid && !gnt_lock) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Memory-side request and per-port completion follow the grant; idle drives an all-zero payload.
  always_comb begin
    o_VALID    = 1'b0;
    o_P0_READY = 1'b0;
    o_P1_READY = 1'b0;
    sel_req    = '0;
    unique case (state_q)
      ARB_GNT0: begin
        o_VALID    = i_P0_VALID;
        o_P0_READY = i_READY & i_P0_VALID;
        sel_req    = p0_req;
      end
      ARB_GNT1: begin
        o_VALID    = i_P1_VALID;
        o_P1_READY = i_READY & i_P1_VALID;
        sel_req    = p1_req;
      end
      default: ;
    endcase
  end

  assign o_ADDR     = ADDR_W'(sel_req.addr);
  assign o_WDATA    = sel_req.wdata;
  assign o_BMASK    = sel_req.bmask;
  assign o_WREN     = sel_req.wren;

  assign o_P0_RDATA = i_RDATA;
  assign o_P1_RDATA = i_RDATA;

  assign o_GNT      = {state_q == ARB_GNT1, state_q == ARB_GNT0};
  assign o_BUSY     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run, all compared
// every cycle against a transaction-level model of who owns the memory port.
module tb_dmem_arbiter;

  localparam int LOCK_MAX = 4;
  localparam int ADDR_W   = 18;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]        valid, lock, wren;
  logic [ADDR_W-1:0] addr [2];
  logic [31:0]       wdata [2];
  logic [3:0]        bmask [2];
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  logic              p0_ready, p1_ready, m_valid, m_wren, busy;
  logic [31:0]       p0_rdata, p1_rdata, m_wdata;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_bmask;
  logic [1:0]        gnt;

  dmem_arbiter #(.LOCK_MAX(LOCK_MAX), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_P0_VALID(valid[0]), .o_P0_READY(p0_ready), .i_P0_ADDR(addr[0]), .i_P0_WDATA(wdata[0]),
    .i_P0_BMASK(bmask[0]), .i_P0_WREN(wren[0]), .i_P0_LOCK(lock[0]), .o_P0_RDATA(p0_rdata),
    .i_P1_VALID(valid[1]), .o_P1_READY(p1_ready), .i_P1_ADDR(addr[1]), .i_P1_WDATA(wdata[1]),
    .i_P1_BMASK(bmask[1]), .i_P1_WREN(wren[1]), .i_P1_LOCK(lock[1]), .o_P1_RDATA(p1_rdata),
    .o_VALID(m_valid), .i_READY(mem_ready), .o_ADDR(m_addr), .o_WDATA(m_wdata),
    .o_BMASK(m_bmask), .o_WREN(m_wren), .i_RDATA(mem_rdata),
    .o_GNT(gnt), .o_BUSY(busy)
  );

  // Reference model: owning port (-1 = none), port granted last, transfers done under this grant.
  int m_owner, m_last, m_done;
  int pend [2];
  int sram_wait;
  int rdy_mode;
  bit rand_mode, write_only;
  int hs_log [$];
  int dut_rdy_cnt [2];
  int model_hs_cnt [2];
  logic [1:0] obs_gnt, obs_ready;
  logic       obs_mvalid;
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic newPayload(input int p);
    addr[p]       = ADDR_W'($urandom);
    addr[p][1:0]  = 2'b00;
    wdata[p]      = $urandom;
    bmask[p]      = 4'($urandom_range(15, 1));
    wren[p]       = write_only ? 1'b1 : 1'($urandom_range(1));
  endtask

  task automatic applyStimulus(input int p, input int count, input bit lk);
    pend[p] = count;
    lock[p] = lk;
    if (count > 0) newPayload(p);
    valid[p] = (count > 0);
  endtask

  // One clock: check outputs mid-cycle, advance the model, then let requesters react after the edge.
  task automatic stepCycle();
    logic              e_valid, e_wren, e_busy;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_wdata;
    logic [3:0]        e_bmask;
    logic [1:0]        e_gnt, e_ready, hs;
    int o;
    @(negedge clk);
    o = m_owner;
    e_valid = 1'b0; e_wren = 1'b0; e_busy = 1'b0; e_addr = '0; e_wdata = '0; e_bmask = '0;
    e_gnt = '0; e_ready = '0;
    if (o >= 0) begin
      e_valid    = valid[o];
      e_addr     = addr[o];
      e_wdata    = wdata[o];
      e_bmask    = bmask[o];
      e_wren     = wren[o];
      e_busy     = 1'b1;
      e_gnt[o]   = 1'b1;
      e_ready[o] = mem_ready & valid[o];
    end
    checkOutput("gnt", 64'(gnt), 64'(e_gnt));
    checkOutput("busy", 64'(busy), 64'(e_busy));
    checkOutput("mem_valid", 64'(m_valid), 64'(e_valid));
    checkOutput("p0_ready", 64'(p0_ready), 64'(e_ready[0]));
    checkOutput("p1_ready", 64'(p1_ready), 64'(e_ready[1]));
    checkOutput("mem_addr", 64'(m_addr), 64'(e_addr));
    checkOutput("mem_wdata", 64'(m_wdata), 64'(e_wdata));
    checkOutput("mem_bmask", 64'(m_bmask), 64'(e_bmask));
    checkOutput("mem_wren", 64'(m_wren), 64'(e_wren));
    checkOutput("p0_rdata", 64'(p0_rdata), 64'(mem_rdata));
    checkOutput("p1_rdata", 64'(p1_rdata), 64'(mem_rdata));
    obs_gnt    = gnt;
    obs_ready  = {p1_ready, p0_ready};
    obs_mvalid = m_valid;
    if (p0_ready === 1'b1) dut_rdy_cnt[0]++;
    if (p1_ready === 1'b1) dut_rdy_cnt[1]++;
    hs = e_ready;
    for (int p = 0; p < 2; p++) begin
      if (hs[p]) begin
        hs_log.push_back(p);
        model_hs_cnt[p]++;
      end
    end
    if (!rst_n) begin
      m_owner = -1; m_last = 1; m_done = 0;
    end else if (o < 0) begin
      if (valid[0] && valid[1]) m_owner = 1 - m_last;
      else if (valid[0])        m_owner = 0;
      else if (valid[1])        m_owner = 1;
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_done = 0;
      end
    end else if (hs[o]) begin
      m_done++;
      if (!(lock[o] && m_done < LOCK_MAX)) m_owner = -1;
    end else if (!valid[o] && !lock[o]) begin
      m_owner = -1;
    end
    if (m_owner >= 0 && m_owner == o && valid[o] && !hs[o]) sram_wait++;
    else sram_wait = 0;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (hs[p]) begin
        pend[p]--;
        if (pend[p] > 0) newPayload(p);
      end
      if (rand_mode) begin
        if (pend[p] == 0 && $urandom_range(3) == 0) begin
          pend[p] = 1 + $urandom_range(2);
          newPayload(p);
        end
        lock[p] = ($urandom_range(2) == 0);
      end
      valid[p] = (pend[p] > 0);
    end
    case (rdy_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = 1'($urandom_range(1));
      default: mem_ready = (m_owner >= 0 && sram_wait >= 2);
    endcase
    mem_rdata = $urandom;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    valid = '0; lock = '0; pend[0] = 0; pend[1] = 0;
    rand_mode = 1'b0;
    stepCycle();
    rst_n = 1'b1;
  endtask

  task automatic checkLog(input string tag, input int exp_seq [$]);
    checkOutput({tag, "_len_ok"}, 64'(hs_log.size() >= exp_seq.size()), 64'(1));
    for (int i = 0; i < exp_seq.size(); i++) begin
      if (i < hs_log.size()) checkOutput(tag, 64'(hs_log[i]), 64'(exp_seq[i]));
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = '0; lock = '0; wren = '0;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; wdata[p] = '0; bmask[p] = '0; pend[p] = 0;
      dut_rdy_cnt[p] = 0; model_hs_cnt[p] = 0;
    end
    mem_ready = 1'b0; mem_rdata = '0; rdy_mode = 0; sram_wait = 0;
    rand_mode = 1'b0; write_only = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_owner = -1; m_last = 1; m_done = 0;
    rst_n = 1'b1;
    stepCycle();
    checkOutput("reset_gnt", 64'(obs_gnt), 64'(0));
    checkOutput("reset_valid", 64'(obs_mvalid), 64'(0));

    // Single read from a flop memory.
    rdy_mode = 0;
    applyStimulus(0, 1, 1'b0);
    addr[0] = 18'h00010;
    wren[0] = 1'b0;
    stepCycle();
    checkOutput("t1_cycle0_valid", 64'(obs_mvalid), 64'(0));
    stepCycle();
    checkOutput("t1_cycle1_gnt", 64'(obs_gnt), 64'(2'b01));
    checkOutput("t1_cycle1_ready", 64'(obs_ready), 64'(2'b01));
    stepCycle();
    checkOutput("t1_cycle2_idle", 64'(obs_gnt), 64'(0));

    // Both ports writing from reset, unlocked: strict alternation starting with P0.
    doReset();
    write_only = 1'b1;
    hs_log.delete();
    applyStimulus(0, 4, 1'b0);
    applyStimulus(1, 4, 1'b0);
    repeat (18) stepCycle();
    checkLog("t2_order", '{0, 1, 0, 1, 0, 1, 0, 1});
    write_only = 1'b0;

    // Slow memory with P1 granted while P0 arrives.
    doReset();
    rdy_mode = 2;
    hs_log.delete();
    applyStimulus(1, 1, 1'b0);
    stepCycle();
    applyStimulus(0, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("t3_hold_gnt", 64'(obs_gnt), 64'(2'b10));
      checkOutput("t3_hold_valid", 64'(obs_mvalid), 64'(1));
      checkOutput("t3_ready", 64'(obs_ready), 64'((i == 2) ? 2'b10 : 2'b00));
    end
    repeat (6) stepCycle();
    checkLog("t3_order", '{1, 0});

    // Lock budget: P0 locked and hungry, P1 waiting.
    doReset();
    rdy_mode = 0;
    hs_log.delete();
    applyStimulus(0, 6, 1'b1);
    applyStimulus(1, 1, 1'b0);
    repeat (10) stepCycle();
    checkLog("t4_budget", '{0, 0, 0, 0, 1});

    // Lock held with no request keeps the grant without spending budget.
    doReset();
    hs_log.delete();
    applyStimulus(0, 1, 1'b1);
    repeat (2) stepCycle();
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("t5_lock_wait_gnt", 64'(obs_gnt), 64'(2'b01));
    end
    applyStimulus(0, 5, 1'b1);
    applyStimulus(1, 1, 1'b0);
    repeat (8) stepCycle();
    checkLog("t5_budget", '{0, 0, 0, 0, 1});

    // Dropping the lock while idle-waiting releases the grant on the next cycle.
    doReset();
    applyStimulus(0, 1, 1'b1);
    repeat (4) stepCycle();
    lock[0] = 1'b0;
    stepCycle();
    checkOutput("t5_drop_still_gnt", 64'(obs_gnt), 64'(2'b01));
    stepCycle();
    checkOutput("t5_drop_idle", 64'(obs_gnt), 64'(0));

    // Reset in the middle of a slow transfer.
    doReset();
    rdy_mode = 2;
    applyStimulus(1, 1, 1'b0);
    repeat (2) stepCycle();
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(1, 0, 1'b0);
    stepCycle();
    checkOutput("t6_gnt", 64'(obs_gnt), 64'(0));
    checkOutput("t6_valid", 64'(obs_mvalid), 64'(0));
    checkOutput("t6_ready", 64'(obs_ready), 64'(0));

    // Randomized traffic, locks and memory latency.
    doReset();
    rdy_mode = 1;
    rand_mode = 1'b1;
    repeat (3000) stepCycle();
    checkOutput("rand_p0_count", 64'(dut_rdy_cnt[0]), 64'(model_hs_cnt[0]));
    checkOutput("rand_p1_count", 64'(dut_rdy_cnt[1]), 64'(model_hs_cnt[1]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
